// File: rtl/dds_period_meter.sv
// DDS output period meter: counts CLK cycles between zero_address rising edges and reports them.
// Optional per-period signed peak tracking is built when PEAK_TRACK_EN is defined.
module dds_period_meter #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  SET,
   input  logic [DATA_WIDTH-1:0] value,
   input  logic                  zero_address,
   output logic [CNT_WIDTH-1:0]  period,
   output logic [DATA_WIDTH-1:0] peak_max,
   output logic [DATA_WIDTH-1:0] peak_min,
   output logic                  result_valid,
   output logic                  overflow,
   output logic                  busy
);

   typedef enum logic {WAIT_ZERO, MEASURE} state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   state_t               state;
   logic [CNT_WIDTH-1:0] cnt;
   logic                 ovf;
   logic                 zero_d;
   logic                 zero_edge;

   assign zero_edge = zero_address & ~zero_d;

   // A period of exactly 2^CNT_WIDTH cycles would wrap cnt+1 to zero, so clamp it too.
   function automatic logic [CNT_WIDTH-1:0] sat_period(input logic [CNT_WIDTH-1:0] c,
                                                       input logic o);
      return (o || c == CNT_MAX) ? CNT_MAX : c + CNT_ONE;
   endfunction

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state        <= WAIT_ZERO;
         cnt          <= '0;
         ovf          <= 1'b0;
         zero_d       <= 1'b0;
         period       <= '0;
         overflow     <= 1'b0;
         result_valid <= 1'b0;
         busy         <= 1'b0;
      end else begin
         zero_d       <= zero_address;
         result_valid <= 1'b0;
         if (SET) begin
            state <= WAIT_ZERO;
            busy  <= 1'b0;
            cnt   <= '0;
            ovf   <= 1'b0;
         end else begin
            case (state)
               WAIT_ZERO: begin
                  if (zero_edge) begin
                     state <= MEASURE;
                     busy  <= 1'b1;
                     cnt   <= '0;
                     ovf   <= 1'b0;
                  end
               end
               MEASURE: begin
                  if (zero_edge) begin
                     period       <= sat_period(cnt, ovf);
                     overflow     <= ovf | (cnt == CNT_MAX);
                     result_valid <= 1'b1;
                     cnt          <= '0;
                     ovf          <= 1'b0;
                  end else if (cnt == CNT_MAX) begin
                     ovf <= 1'b1;
                  end else begin
                     cnt <= cnt + CNT_ONE;
                  end
               end
               default: begin
                  state <= WAIT_ZERO;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef PEAK_TRACK_EN
   logic signed [DATA_WIDTH-1:0] value_s;
   logic signed [DATA_WIDTH-1:0] run_max;
   logic signed [DATA_WIDTH-1:0] run_min;

   assign value_s = value;

   function automatic logic signed [DATA_WIDTH-1:0] smax(input logic signed [DATA_WIDTH-1:0] a,
                                                         input logic signed [DATA_WIDTH-1:0] b);
      return (a > b) ? a : b;
   endfunction

   function automatic logic signed [DATA_WIDTH-1:0] smin(input logic signed [DATA_WIDTH-1:0] a,
                                                         input logic signed [DATA_WIDTH-1:0] b);
      return (a < b) ? a : b;
   endfunction

   // Running extrema include the edge-cycle sample and exclude the closing edge sample.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         run_max  <= '0;
         run_min  <= '0;
         peak_max <= '0;
         peak_min <= '0;
      end else if (!SET) begin
         if (zero_edge) begin
            if (state == MEASURE) begin
               peak_max <= run_max;
               peak_min <= run_min;
            end
            run_max <= value_s;
            run_min <= value_s;
         end else if (state == MEASURE) begin
            run_max <= smax(run_max, value_s);
            run_min <= smin(run_min, value_s);
         end
      end
   end
`else
   assign peak_max = '0;
   assign peak_min = '0;
`endif

endmodule
